ifetch: RTL

Instruction fetch stage feeding the if_id register ahead of the decoder. Holds the PC, issues in-order word requests to instruction memory over a valid/ready request channel, and pairs each returned word with its PC. The instruction/PC pair is presented to the decode side over a valid/ready handshake. Handles redirects from the execute stage by flushing buffered words and discarding stale in-flight responses.

---
 rtl/ifetch_if.sv | 37 +++
 rtl/ifetch.sv | 134 +++++++++++++
 2 files changed

// File: rtl/ifetch_if.sv
// Fetch-stage bus bundle: instruction-memory request/response channel, decode-side
// valid/ready channel and the execute-stage redirect.
//   imem_req_valid_o/ready_i/addr_o : in-order word fetch requests
//   imem_rsp_valid_i/data_i         : responses, always accepted, in request order
//   id_valid_o/ready_i/instr_o/pc_o : instruction/PC pair towards decode
//   redirect_i/redirect_pc_i        : one-cycle restart pulse and its target PC
// Signal suffixes are from the fetch stage's point of view (modport master).
interface ifetch_if #(
    parameter int unsigned PC_WIDTH    = 32,
    parameter int unsigned INSTR_WIDTH = 32
);
    logic                   imem_req_valid_o;
    logic                   imem_req_ready_i;
    logic [PC_WIDTH-1:0]    imem_req_addr_o;
    logic                   imem_rsp_valid_i;
    logic [INSTR_WIDTH-1:0] imem_rsp_data_i;
    logic                   id_valid_o;
    logic                   id_ready_i;
    logic [INSTR_WIDTH-1:0] id_instr_o;
    logic [PC_WIDTH-1:0]    id_pc_o;
    logic                   redirect_i;
    logic [PC_WIDTH-1:0]    redirect_pc_i;

    // Fetch stage side
    modport master (
        output imem_req_valid_o, imem_req_addr_o, id_valid_o, id_instr_o, id_pc_o,
        input  imem_req_ready_i, imem_rsp_valid_i, imem_rsp_data_i, id_ready_i,
        input  redirect_i, redirect_pc_i
    );

    // Memory / decode / execute side
    modport slave (
        input  imem_req_valid_o, imem_req_addr_o, id_valid_o, id_instr_o, id_pc_o,
        output imem_req_ready_i, imem_rsp_valid_i, imem_rsp_data_i, id_ready_i,
        output redirect_i, redirect_pc_i
    );
endinterface

// File: rtl/ifetch.sv
// Instruction fetch stage. Holds the PC, issues in-order word fetches, pairs each
// returned word with its PC in a 2-entry output buffer and hands pairs to decode.
// A redirect flushes everything buffered and drops responses of requests that were
// already in flight.
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : ifetch_if.master (memory request/response, decode handshake, redirect)
module ifetch #(
    parameter int unsigned          PC_WIDTH    = 32,
    parameter int unsigned          INSTR_WIDTH = 32,
    parameter logic [PC_WIDTH-1:0]  RESET_PC    = 32'h8000_0000
) (
    input  logic     clk,
    input  logic     rst_n,
    ifetch_if.master bus
);

    logic [PC_WIDTH-1:0]    pc_q, pc_d;
    // PCs of live in-flight requests, head at index 0
    logic [PC_WIDTH-1:0]    rq_pc_q [2];
    logic [PC_WIDTH-1:0]    rq_pc_d [2];
    logic [1:0]             rq_cnt_q, rq_cnt_d;
    // Output buffer of {pc, instr}, head at index 0
    logic [PC_WIDTH-1:0]    ob_pc_q [2];
    logic [PC_WIDTH-1:0]    ob_pc_d [2];
    logic [INSTR_WIDTH-1:0] ob_instr_q [2];
    logic [INSTR_WIDTH-1:0] ob_instr_d [2];
    logic [1:0]             ob_cnt_q, ob_cnt_d;
    // Responses still owed for requests issued before the last redirect
    logic [1:0]             disc_q, disc_d;

    logic [2:0] used;
    logic [1:0] inflight;
    logic       credit;
    logic       req_valid;
    logic       req_fire;
    logic       rsp_any;
    logic       rsp_drop;
    logic       rsp_live;
    logic       id_valid;
    logic       id_fire;
    logic       unused_redirect_lsb;

    assign unused_redirect_lsb = ^bus.redirect_pc_i[1:0];

    // Stale requests hold their slot until their response returns, so every live
    // response is guaranteed a free buffer entry.
    assign inflight = rq_cnt_q + disc_q;
    assign used     = {1'b0, rq_cnt_q} + {1'b0, disc_q} + {1'b0, ob_cnt_q};
    assign credit   = (used < 3'd2);

    // rst_n gates the request so nothing is offered while reset is held
    assign req_valid = rst_n & credit & ~bus.redirect_i;
    assign req_fire  = req_valid & bus.imem_req_ready_i;

    // A response with nothing in flight is a protocol error and is ignored
    assign rsp_any  = bus.imem_rsp_valid_i & (inflight != 2'd0);
    assign rsp_drop = bus.imem_rsp_valid_i & (disc_q != 2'd0);
    assign rsp_live = bus.imem_rsp_valid_i & (disc_q == 2'd0) & (rq_cnt_q != 2'd0);

    assign id_valid = (ob_cnt_q != 2'd0);
    assign id_fire  = id_valid & bus.id_ready_i;

    always_comb begin
        pc_d       = pc_q;
        rq_pc_d    = rq_pc_q;
        rq_cnt_d   = rq_cnt_q;
        ob_pc_d    = ob_pc_q;
        ob_instr_d = ob_instr_q;
        ob_cnt_d   = ob_cnt_q;
        disc_d     = disc_q;

        if (bus.redirect_i) begin
            pc_d     = {bus.redirect_pc_i[PC_WIDTH-1:2], 2'b00};
            rq_cnt_d = 2'd0;
            ob_cnt_d = 2'd0;
            // A response arriving now belongs to an old request and is dropped here
            disc_d   = inflight - {1'b0, rsp_any};
        end else begin
            if (rsp_live) begin
                rq_pc_d[0] = rq_pc_q[1];
                rq_cnt_d   = rq_cnt_q - 2'd1;
            end
            if (req_fire) begin
                rq_pc_d[rq_cnt_d[0]] = pc_q;
                rq_cnt_d             = rq_cnt_d + 2'd1;
                pc_d                 = pc_q + PC_WIDTH'(4);
            end
            if (rsp_drop) begin
                disc_d = disc_q - 2'd1;
            end
            if (id_fire) begin
                ob_pc_d[0]    = ob_pc_q[1];
                ob_instr_d[0] = ob_instr_q[1];
                ob_cnt_d      = ob_cnt_q - 2'd1;
            end
            if (rsp_live) begin
                ob_pc_d[ob_cnt_d[0]]    = rq_pc_q[0];
                ob_instr_d[ob_cnt_d[0]] = bus.imem_rsp_data_i;
                ob_cnt_d                = ob_cnt_d + 2'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q          <= RESET_PC;
            rq_pc_q[0]    <= '0;
            rq_pc_q[1]    <= '0;
            rq_cnt_q      <= 2'd0;
            ob_pc_q[0]    <= '0;
            ob_pc_q[1]    <= '0;
            ob_instr_q[0] <= '0;
            ob_instr_q[1] <= '0;
            ob_cnt_q      <= 2'd0;
            disc_q        <= 2'd0;
        end else begin
            pc_q       <= pc_d;
            rq_pc_q    <= rq_pc_d;
            rq_cnt_q   <= rq_cnt_d;
            ob_pc_q    <= ob_pc_d;
            ob_instr_q <= ob_instr_d;
            ob_cnt_q   <= ob_cnt_d;
            disc_q     <= disc_d;
        end
    end

    assign bus.imem_req_valid_o = req_valid;
    assign bus.imem_req_addr_o  = pc_q;
    assign bus.id_valid_o       = id_valid;
    assign bus.id_instr_o       = ob_instr_q[0];
    assign bus.id_pc_o          = ob_pc_q[0];

endmodule
